// File: rtl/simd_pkg.sv
// Shared types for the SIMD vector worker: instruction words, job descriptor,
// ALU/lane enums and the per-lane arithmetic helper used by the vector ALU.
package simd_pkg;

  localparam int ADDR_W    = 32;
  localparam int COUNT_W   = 16;
  localparam int INFO_W    = COUNT_W + 6;
  localparam int PAYLOAD_W = (ADDR_W > INFO_W) ? ADDR_W : INFO_W;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    INSTR_NOP  = 2'd0,
    INSTR_LD   = 2'd1,
    INSTR_INFO = 2'd2
  } opcode_e;

  typedef enum logic [1:0] {
    ALU_PASS_A = 2'd0,
    ALU_ADD    = 2'd1,
    ALU_SUB    = 2'd2,
    ALU_MULLO  = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    LANE_8  = 2'd0,
    LANE_16 = 2'd1,
    LANE_32 = 2'd2,
    LANE_64 = 2'd3
  } lane_mode_e;

  typedef struct packed {
    opcode_e                opcode;
    logic [PAYLOAD_W-1:0]   payload;
  } instr_t;

  typedef struct packed {
    logic [COUNT_W-1:0] count;
    alu_op_e            op;
    logic               overwrite;
    logic               sat;
    lane_mode_e         lane_mode;
  } instr_info_t;

  // One lane of width w held in the low bits of a 64-bit word; upper bits of the result are zero.
  function automatic logic [63:0] lane_op(logic [63:0] a, logic [63:0] b, alu_op_e op,
                                          logic sat, int w);
    logic [63:0] mask, sum, dif, smax, smin, res;
    logic [5:0]  msb;
    logic        ovf_add, ovf_sub;
    mask    = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    msb     = 6'(w - 1);
    sum     = (a + b) & mask;
    dif     = (a - b) & mask;
    smax    = mask >> 1;
    smin    = smax + 64'd1;
    ovf_add = (a[msb] == b[msb]) && (sum[msb] != a[msb]);
    ovf_sub = (a[msb] != b[msb]) && (dif[msb] != a[msb]);
    case (op)
      ALU_ADD:   res = (sat && ovf_add) ? (a[msb] ? smin : smax) : sum;
      ALU_SUB:   res = (sat && ovf_sub) ? (a[msb] ? smin : smax) : dif;
      ALU_MULLO: res = (a * b) & mask;
      default:   res = a & mask;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/simd_vec_alu.sv
// Combinational DATA_W-wide SIMD ALU; each 64-bit slice computes all four lane
// widths in parallel and the runtime lane mode picks one.
module simd_vec_alu
  import simd_pkg::*;
#(
  parameter int DATA_W = 128
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  alu_op_e           op_i,
  input  logic              sat_i,
  input  lane_mode_e        lane_mode_i,
  output logic [DATA_W-1:0] y_o
);

  localparam int SLICES = DATA_W / 64;

  for (genvar s = 0; s < SLICES; s++) begin : g_slice
    logic [63:0] sa, sb, r8, r16, r32, r64;

    assign sa = a_i[s*64 +: 64];
    assign sb = b_i[s*64 +: 64];

    always_comb begin
      logic [63:0] t;
      t   = '0;
      r8  = '0;
      r16 = '0;
      r32 = '0;
      for (int i = 0; i < 8; i++) begin
        t = lane_op(64'(sa[i*8 +: 8]), 64'(sb[i*8 +: 8]), op_i, sat_i, 8);
        r8[i*8 +: 8] = t[7:0];
      end
      for (int i = 0; i < 4; i++) begin
        t = lane_op(64'(sa[i*16 +: 16]), 64'(sb[i*16 +: 16]), op_i, sat_i, 16);
        r16[i*16 +: 16] = t[15:0];
      end
      for (int i = 0; i < 2; i++) begin
        t = lane_op(64'(sa[i*32 +: 32]), 64'(sb[i*32 +: 32]), op_i, sat_i, 32);
        r32[i*32 +: 32] = t[31:0];
      end
      r64 = lane_op(sa, sb, op_i, sat_i, 64);
    end

    assign y_o[s*64 +: 64] = (lane_mode_i == LANE_8)  ? r8  :
                             (lane_mode_i == LANE_16) ? r16 :
                             (lane_mode_i == LANE_32) ? r32 : r64;
  end

endmodule

// File: rtl/simd_vproc.sv
// SIMD vector worker: accepts LD/LD/INFO, then loops fetch A, fetch B, ALU,
// write back until the element count is exhausted.
module simd_vproc
  import simd_pkg::*;
#(
  parameter int DATA_W = 128
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_en,
  input  instr_t              i_instr,
  input  logic                i_valid,
  output logic                o_ack,
  output logic                o_req_rd,
  output logic                o_req_wr,
  input  logic                i_grant_rd,
  input  logic                i_grant_wr,
  input  logic [DATA_W-1:0]   i_data,
  output logic [ADDR_W-1:0]   o_addr,
  output logic [DATA_W-1:0]   o_data,
  output logic [1:0]          o_wr_size,
  output logic [DATA_W/8-1:0] o_wr_mask,
  output logic                o_busy,
  output logic                o_finish,
  output logic [3:0]          o_state_dbg
);

  localparam int NBYTES = DATA_W / 8;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LD1    = 4'd1;
  localparam logic [3:0] S_LD2    = 4'd2;
  localparam logic [3:0] S_INFO   = 4'd3;
  localparam logic [3:0] S_FETCH1 = 4'd4;
  localparam logic [3:0] S_FETCH2 = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_WRITE  = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;

  logic [3:0]         state_q, state_d;
  addr_t              addr0_q, addr0_d, addr1_q, addr1_d;
  logic [COUNT_W-1:0] rem_q, rem_d;
  instr_info_t        info_q, info_d, info_in;
  logic [DATA_W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d, alu_y;
  logic [COUNT_W:0]   lanes;
  logic [COUNT_W+2:0] nbytes;
  logic               last_pass, partial;

  assign info_in = instr_info_t'(i_instr.payload[INFO_W-1:0]);

  // Handshakes: o_ack is combinational and means the instruction on i_instr is
  // consumed at the coming edge; a grant is only honoured while the matching
  // request is high, and address/data stay frozen until that grant arrives.
  always_comb begin
    o_ack = 1'b0;
    if (i_valid) begin
      if ((state_q == S_LD1 || state_q == S_LD2) && i_instr.opcode == INSTR_LD) o_ack = 1'b1;
      if (state_q == S_INFO && i_instr.opcode == INSTR_INFO) o_ack = 1'b1;
    end
  end

  simd_vec_alu #(.DATA_W(DATA_W)) u_alu (
    .a_i         (a_q),
    .b_i         (b_q),
    .op_i        (info_q.op),
    .sat_i       (info_q.sat),
    .lane_mode_i (info_q.lane_mode),
    .y_o         (alu_y)
  );

  assign lanes     = (COUNT_W+1)'(NBYTES) >> info_q.lane_mode;
  assign last_pass = {1'b0, rem_q} <= lanes;
  assign partial   = {1'b0, rem_q} < lanes;
  assign nbytes    = (COUNT_W+3)'(rem_q) << info_q.lane_mode;

  always_comb begin
    state_d = state_q;
    addr0_d = addr0_q;
    addr1_d = addr1_q;
    rem_d   = rem_q;
    info_d  = info_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: if (i_en) state_d = S_LD1;
      S_LD1: if (o_ack) begin
        addr0_d = i_instr.payload[ADDR_W-1:0];
        state_d = S_LD2;
      end
      S_LD2: if (o_ack) begin
        addr1_d = i_instr.payload[ADDR_W-1:0];
        state_d = S_INFO;
      end
      S_INFO: if (o_ack) begin
        info_d  = info_in;
        rem_d   = info_in.count;
        state_d = (info_in.count == '0) ? S_DONE : S_FETCH1;
      end
      S_FETCH1: if (i_grant_rd) begin
        a_d     = i_data;
        state_d = S_FETCH2;
      end
      S_FETCH2: if (i_grant_rd) begin
        b_d     = i_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d   = alu_y;
        state_d = S_WRITE;
      end
      S_WRITE: if (i_grant_wr) begin
        if (last_pass) begin
          state_d = S_DONE;
        end else begin
          rem_d   = rem_q - COUNT_W'(lanes);
          addr0_d = addr0_q + ADDR_W'(1);
          addr1_d = addr1_q + ADDR_W'(1);
          state_d = S_FETCH1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      addr0_q <= '0;
      addr1_q <= '0;
      rem_q   <= '0;
      info_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      addr0_q <= addr0_d;
      addr1_q <= addr1_d;
      rem_q   <= rem_d;
      info_q  <= info_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    o_addr = '0;
    case (state_q)
      S_FETCH1: o_addr = addr0_q;
      S_FETCH2: o_addr = addr1_q;
      S_WRITE:  o_addr = info_q.overwrite ? addr0_q : addr1_q;
      default:  o_addr = '0;
    endcase
  end

  // Only the tail pass of a job can be short; its mask covers the live lanes.
  always_comb begin
    o_wr_mask = '0;
    if (state_q == S_WRITE) begin
      for (int i = 0; i < NBYTES; i++) begin
        o_wr_mask[i] = !partial || ((COUNT_W+3)'(i) < nbytes);
      end
    end
  end

  assign o_req_rd    = (state_q == S_FETCH1) || (state_q == S_FETCH2);
  assign o_req_wr    = (state_q == S_WRITE);
  assign o_data      = res_q;
  assign o_wr_size   = info_q.lane_mode;
  assign o_busy      = (state_q != S_IDLE);
  assign o_finish    = (state_q == S_DONE);
  assign o_state_dbg = state_q;

endmodule

// File: tb/tb_simd_vproc.sv
// Randomised bench for simd_vproc: the bench plays dispatcher and memory,
// and every write is compared against a lane-by-lane arithmetic model.
module tb_simd_vproc;
  import simd_pkg::*;

  localparam int DW = 128;
  localparam int NB = DW / 8;
  localparam int EW = ADDR_W + NB + 2 + DW;

  logic          clk = 1'b0;
  logic          rstn, en, valid, ack, req_rd, req_wr, grant_rd, grant_wr, busy, finish;
  instr_t        instr;
  logic [DW-1:0] rdata, wdata;
  addr_t         addr;
  logic [1:0]    wr_size;
  logic [NB-1:0] wr_mask;
  logic [3:0]    state_dbg;

  always #5 clk = ~clk;

  simd_vproc #(.DATA_W(DW)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_en(en), .i_instr(instr), .i_valid(valid), .o_ack(ack),
    .o_req_rd(req_rd), .o_req_wr(req_wr), .i_grant_rd(grant_rd), .i_grant_wr(grant_wr),
    .i_data(rdata), .o_addr(addr), .o_data(wdata), .o_wr_size(wr_size), .o_wr_mask(wr_mask),
    .o_busy(busy), .o_finish(finish), .o_state_dbg(state_dbg)
  );

  int n_checks = 0, n_fail = 0;
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] mem [addr_t];
  addr_t         rd_log[$];
  int            n_writes, n_acks, job_iters, rd_wait, wr_wait;
  bit            saw_rd, junk_en, stall_mode, rd_active, wr_active;
  addr_t         rd_addr_s, wr_addr_s, last_waddr;
  logic [DW-1:0] wr_data_s, last_wdata;
  logic [NB-1:0] wr_mask_s, last_wmask;
  logic [1:0]    wr_size_s;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_vec();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [DW-1:0] get_mem(addr_t a);
    if (!mem.exists(a)) mem[a] = rand_vec();
    return mem[a];
  endfunction

  // Lane values interpreted as signed integers, combined, clamped, reduced mod 2^w.
  function automatic logic [DW-1:0] ref_vec(logic [DW-1:0] a, logic [DW-1:0] b, int op,
                                            bit sat, int lm);
    int w = 8 << lm;
    logic signed [DW+1:0] pow, sa, sb, r, maxv, minv;
    logic [DW-1:0] lmask, ua, ub, res, out;
    pow   = (DW+2)'(1) << w;
    lmask = DW'(pow - 1);
    maxv  = (pow >>> 1) - 1;
    minv  = -(pow >>> 1);
    out   = '0;
    for (int i = 0; i < DW / w; i++) begin
      ua = (a >> (i * w)) & lmask;
      ub = (b >> (i * w)) & lmask;
      sa = $signed({2'b00, ua});
      sb = $signed({2'b00, ub});
      if (sa >= (pow >>> 1)) sa = sa - pow;
      if (sb >= (pow >>> 1)) sb = sb - pow;
      if (op == 1 || op == 2) begin
        r = (op == 1) ? sa + sb : sa - sb;
        if (sat && r > maxv) r = maxv;
        if (sat && r < minv) r = minv;
        res = DW'(r) & lmask;
      end else if (op == 3) begin
        res = (ua * ub) & lmask;
      end else begin
        res = ua;
      end
      out = out | (res << (i * w));
    end
    return out;
  endfunction

  task automatic take_write();
    logic [EW-1:0] e;
    n_writes++;
    last_waddr = addr;
    last_wdata = wdata;
    last_wmask = wr_mask;
    if (exp_q.size() == 0) begin
      check("wr_unexpected", DW'(1), DW'(0));
    end else begin
      e = exp_q.pop_front();
      check("wr_addr", DW'(addr), DW'(e[DW+2+NB +: ADDR_W]));
      check("wr_mask", DW'(wr_mask), DW'(e[DW+2 +: NB]));
      check("wr_size", DW'(wr_size), DW'(e[DW +: 2]));
      check("wr_data", wdata, e[DW-1:0]);
    end
  endtask

  // Advance to the next falling edge and act as the memory arbiter for that cycle.
  task automatic tick();
    @(negedge clk);
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    rdata    = '0;
    if (rd_active && !req_rd) begin
      check("rd_req_held", DW'(req_rd), DW'(1));
      rd_active = 1'b0;
    end
    if (wr_active && !req_wr) begin
      check("wr_req_held", DW'(req_wr), DW'(1));
      wr_active = 1'b0;
    end
    if (req_rd) begin
      if (!rd_active) begin
        rd_active = 1'b1;
        rd_wait   = stall_mode ? 10 : int'($urandom_range(0, 3));
        rd_addr_s = addr;
      end else if (stall_mode) begin
        check("rd_addr_stable", DW'(addr), DW'(rd_addr_s));
      end
      if (rd_wait > 0) begin
        rd_wait--;
      end else begin
        grant_rd  = 1'b1;
        rdata     = get_mem(addr);
        rd_log.push_back(addr);
        saw_rd    = 1'b1;
        rd_active = 1'b0;
      end
    end else if (junk_en && $urandom_range(0, 3) == 0) begin
      grant_rd = 1'b1;
      rdata    = rand_vec();
    end
    if (req_wr) begin
      if (!wr_active) begin
        wr_active = 1'b1;
        wr_wait   = stall_mode ? 10 : int'($urandom_range(0, 3));
        wr_addr_s = addr;
        wr_data_s = wdata;
        wr_mask_s = wr_mask;
        wr_size_s = wr_size;
      end else if (stall_mode) begin
        check("wr_addr_stable", DW'(addr), DW'(wr_addr_s));
        check("wr_data_stable", wdata, wr_data_s);
        check("wr_mask_stable", DW'(wr_mask), DW'(wr_mask_s));
        check("wr_size_stable", DW'(wr_size), DW'(wr_size_s));
      end
      if (wr_wait > 0) begin
        wr_wait--;
      end else begin
        grant_wr  = 1'b1;
        wr_active = 1'b0;
        take_write();
      end
    end else if (junk_en && $urandom_range(0, 3) == 0) begin
      grant_wr = 1'b1;
    end
  endtask

  task automatic issue(input opcode_e opc, input logic [PAYLOAD_W-1:0] pl);
    int nbad = int'($urandom_range(0, 2));
    for (int i = 0; i < nbad; i++) begin
      valid         = 1'($urandom_range(0, 1));
      instr.opcode  = ($urandom_range(0, 1) == 0) ? INSTR_NOP :
                      ((opc == INSTR_LD) ? INSTR_INFO : INSTR_LD);
      instr.payload = PAYLOAD_W'($urandom());
      #1 check("ack_wrong", DW'(ack), DW'(0));
      tick();
    end
    valid         = 1'b1;
    instr.opcode  = opc;
    instr.payload = pl;
    #1 check("ack_good", DW'(ack), DW'(1));
    if (ack) n_acks++;
    tick();
    valid = 1'b0;
  endtask

  task automatic start_job(input addr_t a0, input addr_t a1, input int cnt, input int op,
                           input bit ow, input bit sat, input int lm);
    int          lanes, rem, nbytes;
    addr_t       ak, bk;
    logic [31:0] m32;
    logic [NB-1:0] m;
    instr_info_t info;
    lanes     = NB >> lm;
    job_iters = (cnt + lanes - 1) / lanes;
    for (int k = 0; k < job_iters; k++) begin
      ak  = a0 + addr_t'(k);
      bk  = a1 + addr_t'(k);
      rem = cnt - k * lanes;
      if (rem >= lanes) begin
        m = '1;
      end else begin
        nbytes = rem << lm;
        m32    = (32'd1 << nbytes) - 32'd1;
        m      = NB'(m32);
      end
      exp_q.push_back({ow ? ak : bk, m, 2'(lm), ref_vec(get_mem(ak), get_mem(bk), op, sat, lm)});
    end
    n_writes = 0;
    n_acks   = 0;
    saw_rd   = 1'b0;
    rd_log.delete();
    info = '{count: COUNT_W'(cnt), op: alu_op_e'(op), overwrite: ow, sat: sat,
             lane_mode: lane_mode_e'(lm)};
    tick();
    en = 1'b1;
    tick();
    en = 1'b0;
    issue(INSTR_LD, PAYLOAD_W'(a0));
    issue(INSTR_LD, PAYLOAD_W'(a1));
    issue(INSTR_INFO, PAYLOAD_W'(info));
  endtask

  task automatic wait_done(input bit zero_count);
    int cyc = 0;
    check("busy_during", DW'(busy), DW'(1));
    while (!finish && cyc < 3000) begin
      en    = junk_en ? 1'($urandom_range(0, 1)) : 1'b0;
      valid = junk_en ? 1'($urandom_range(0, 1)) : 1'b0;
      instr = instr_t'({$urandom(), $urandom()});
      if (valid) #1 check("ack_outside", DW'(ack), DW'(0));
      tick();
      cyc++;
    end
    en    = 1'b0;
    valid = 1'b0;
    check("finish_seen", DW'(finish), DW'(1));
    if (zero_count) check("finish_latency0", DW'(cyc), DW'(0));
    check("writes", DW'(n_writes), DW'(job_iters));
    check("exp_q_empty", DW'(exp_q.size()), DW'(0));
    tick();
    check("finish_pulse", DW'(finish), DW'(0));
    check("busy_after", DW'(busy), DW'(0));
    exp_q.delete();
  endtask

  task automatic abort_job();
    bit found = 1'b0;
    start_job(addr_t'(40), addr_t'(41), 8, 1, 1'b0, 1'b0, 2);
    for (int i = 0; i < 200 && !found; i++) begin
      if (req_rd && addr == addr_t'(41)) found = 1'b1;
      else tick();
    end
    check("reached_fetch2", DW'(found), DW'(1));
    #2 rstn = 1'b0;
    #1;
    check("abort_req_rd", DW'(req_rd), DW'(0));
    check("abort_busy", DW'(busy), DW'(0));
    check("abort_finish", DW'(finish), DW'(0));
    rd_active = 1'b0;
    wr_active = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_no_finish", DW'(finish), DW'(0));
    end
    rstn = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_abort_idle", DW'({finish, busy, req_rd, req_wr}), DW'(0));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rstn = 1'b0; en = 1'b0; valid = 1'b0; instr = '0;
    grant_rd = 1'b0; grant_wr = 1'b0; rdata = '0;
    junk_en = 1'b0; stall_mode = 1'b0; rd_active = 1'b0; wr_active = 1'b0;
    #12;
    check("rst_ctrl", DW'({busy, finish, ack, req_rd, req_wr}), DW'(0));
    check("rst_addr", DW'(addr), DW'(0));
    check("rst_data", wdata, DW'(0));
    check("rst_mask_size", DW'({wr_mask, wr_size}), DW'(0));
    @(negedge clk);
    rstn = 1'b1;

    mem[addr_t'(1)] = {4{32'd5}};
    mem[addr_t'(2)] = {4{32'd7}};
    start_job(addr_t'(1), addr_t'(2), 4, 2, 1'b0, 1'b0, 2);
    check("load_acks", DW'(n_acks), DW'(3));
    wait_done(1'b0);
    check("sub32_data", last_wdata, {4{32'hFFFFFFFE}});
    check("sub32_addr", DW'(last_waddr), DW'(2));

    mem[addr_t'(20)] = {4{32'h7FFFFFFF}};
    mem[addr_t'(21)] = {4{32'h00000001}};
    start_job(addr_t'(20), addr_t'(21), 4, 1, 1'b1, 1'b1, 2);
    wait_done(1'b0);
    check("sat_add_data", last_wdata, {4{32'h7FFFFFFF}});
    check("sat_add_addr", DW'(last_waddr), DW'(20));

    mem[addr_t'(30)] = {16{8'd16}};
    mem[addr_t'(31)] = {16{8'd17}};
    start_job(addr_t'(30), addr_t'(31), 16, 3, 1'b0, 1'b0, 0);
    wait_done(1'b0);
    check("mullo8_data", last_wdata, {16{8'h10}});

    start_job(addr_t'(1), addr_t'(100), 20, 1, 1'b1, 1'b0, 1);
    wait_done(1'b0);
    check("loop_writes", DW'(n_writes), DW'(3));
    check("loop_last_addr", DW'(last_waddr), DW'(3));
    check("loop_last_mask", DW'(last_wmask), DW'(16'h00FF));

    start_job(addr_t'(5), addr_t'(6), 0, 1, 1'b0, 1'b0, 0);
    wait_done(1'b1);
    check("count0_no_rd", DW'(saw_rd), DW'(0));

    start_job(addr_t'(32'hFFFFFFFF), addr_t'(200), 3, 0, 1'b1, 1'b0, 3);
    wait_done(1'b0);
    check("wrap_rd_count", DW'(rd_log.size()), DW'(4));
    if (rd_log.size() >= 3) check("wrap_fetch_addr", DW'(rd_log[2]), DW'(0));
    check("wrap_last_addr", DW'(last_waddr), DW'(0));

    stall_mode = 1'b1;
    start_job(addr_t'(300), addr_t'(301), 2, 2, 1'b0, 1'b1, 3);
    wait_done(1'b0);
    stall_mode = 1'b0;

    abort_job();

    junk_en = 1'b1;
    repeat (25) begin
      addr_t a0;
      a0 = addr_t'($urandom());
      start_job(a0, a0 + addr_t'($urandom_range(0, 5000)), int'($urandom_range(0, 40)),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      wait_done(job_iters == 0);
    end
    junk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
